// File: rtl/swport_pkg.sv
// Shared definitions for the switch input port: register word offsets on the
// MIO data bus and the bus register width.
package swport_pkg;

  localparam int SWPORT_REG_W = 32;

  localparam logic [1:0] SWPORT_DATA = 2'd0;
  localparam logic [1:0] SWPORT_EDGE = 2'd1;
  localparam logic [1:0] SWPORT_MASK = 2'd2;
  localparam logic [1:0] SWPORT_RAW  = 2'd3;

endpackage

// File: rtl/debounce_cell.sv
// One switch bit: two-flop synchronizer, tick-based stability counter and the
// accepted (debounced) level. accept pulses for the single cycle in which the
// accepted level changes, so the parent can record a change event.
module debounce_cell #(
  parameter int STABLE_N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  input  logic tick,
  output logic raw,
  output logic level,
  output logic accept
);

  localparam int CNT_W = $clog2(STABLE_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_N - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // Counting one more differing tick from STABLE_N-1 would reach STABLE_N:
  // that tick accepts the new level instead of incrementing.
  assign accept = tick && (sync2_q != level_q) && (cnt_q == CNT_LAST);
  assign raw    = sync2_q;
  assign level  = level_q;

  // Synchronizer and per-tick stability tracking; the counter saturates by
  // construction because reaching its last value forces acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      if (tick) begin
        if (sync2_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sw_input_port.sv
// Memory-mapped switch input responder on the MIO data bus.
// Offsets: 0 DATA (debounced, RO), 1 EDGE (sticky change flags, W1C),
// 2 MASK (irq enable, RW), 3 RAW (synchronized, RO).
// Build option SWPORT_IRQ_EN: when defined, the MASK register and the
// registered irq output exist; otherwise offset 2 reads 0 and irq is 0.
//
// Bus access has no valid/ready handshake: a write is cs & mem_w sampled at
// the rising edge of clk and takes effect at that edge; rdata is a
// combinational function of addr, valid whether or not cs is asserted.
module sw_input_port
  import swport_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 50000,
  parameter int STABLE_N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        sw_i,
  input  logic                    cs,
  input  logic                    mem_w,
  input  logic [1:0]              addr,
  input  logic [SWPORT_REG_W-1:0] wdata,
  output logic [SWPORT_REG_W-1:0] rdata,
  output logic                    irq
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] presc_q;
  logic             tick;
  logic [WIDTH-1:0] raw_v;
  logic [WIDTH-1:0] data_v;
  logic [WIDTH-1:0] accept_v;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_clr;
  logic             wr_en;
  logic             wdata_unused;

  assign tick  = (presc_q == PRE_LAST);
  assign wr_en = cs && mem_w;

  // Write data above WIDTH has no register bit to land in.
  assign wdata_unused = ^wdata;

  // Free-running debounce sample prescaler, 0..TICK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    debounce_cell #(
      .STABLE_N(STABLE_N)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .sw     (sw_i[i]),
      .tick   (tick),
      .raw    (raw_v[i]),
      .level  (data_v[i]),
      .accept (accept_v[i])
    );
  end

  assign edge_clr = (wr_en && (addr == SWPORT_EDGE)) ? wdata[WIDTH-1:0] : '0;

  // Sticky change flags: an acceptance in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | accept_v;
    end
  end

`ifdef SWPORT_IRQ_EN
  logic [WIDTH-1:0] mask_q;

  // Interrupt enable register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
    end else if (wr_en && (addr == SWPORT_MASK)) begin
      mask_q <= wdata[WIDTH-1:0];
    end
  end

  // Registered interrupt: any enabled pending change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_q & mask_q);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux; bits above WIDTH always read 0.
  always_comb begin
    rdata = '0;
    case (addr)
      SWPORT_DATA: rdata[WIDTH-1:0] = data_v;
      SWPORT_EDGE: rdata[WIDTH-1:0] = edge_q;
`ifdef SWPORT_IRQ_EN
      SWPORT_MASK: rdata[WIDTH-1:0] = mask_q;
`else
      SWPORT_MASK: rdata = '0;
`endif
      SWPORT_RAW:  rdata[WIDTH-1:0] = raw_v;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sw_input_port.sv
// Bench for sw_input_port with TICK_DIV=4, STABLE_N=3, WIDTH=16.
// Directed scenarios (reset, clean change latency window, W1C, interrupt,
// bounce, set/clear collision, async reset mid-debounce) followed by random
// switch values and glitches checked against a hold-time level model.
`timescale 1ns/1ps
module tb_sw_input_port;

  localparam int WIDTH    = 16;
  localparam int TICK_DIV = 4;
  localparam int STABLE_N = 3;
  // Long enough for sync (2) plus worst-case acceptance (STABLE_N ticks).
  localparam int HOLD     = 2 + STABLE_N * TICK_DIV + 2;

`ifdef SWPORT_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_EDGE = 2'd1;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_RAW  = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw_i;
  logic             cs;
  logic             mem_w;
  logic [1:0]       addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             irq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  // Clock / reset block
  always #10 clk = ~clk;

  sw_input_port #(
    .WIDTH   (WIDTH),
    .TICK_DIV(TICK_DIV),
    .STABLE_N(STABLE_N)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sw_i (sw_i),
    .cs   (cs),
    .mem_w(mem_w),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cs    = 1'b1;
    mem_w = 1'b1;
    addr  = a;
    wdata = d;
    step(1);
    cs    = 1'b0;
    mem_w = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  logic [31:0]      d, e;
  int               hit;
  logic [WIDTH-1:0] model_data, model_edge, model_mask, cur, nxt, g;
  logic [31:0]      w, m;

  initial begin
    rst   = 1'b1;
    sw_i  = '0;
    cs    = 1'b0;
    mem_w = 1'b0;
    addr  = 2'd0;
    wdata = '0;

    // Reset state
    step(2);
    check_reg("rst_data", A_DATA, 32'h0);
    check_reg("rst_edge", A_EDGE, 32'h0);
    check_reg("rst_mask", A_MASK, 32'h0);
    check_reg("rst_raw",  A_RAW,  32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(3);

    // Clean change 0x0000 -> 0x0005
    sw_i = 16'h0005;
    step(1);
    check_reg("raw_after_1", A_RAW, 32'h0);
    step(1);
    check_reg("raw_after_2", A_RAW, 32'h5);
    hit = 0;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      rd(A_DATA, d);
      if (k < 9) check("data_not_early", d, 32'h0);
      if (hit == 0 && d == 32'h5) begin
        hit = k;
        check_reg("edge_with_data", A_EDGE, 32'h5);
      end
    end
    check("data_latency_window", 32'(hit >= 9 && hit <= 12), 32'h1);

    // W1C and read-only writes
    wr(A_EDGE, 32'h1);
    check_reg("w1c_edge", A_EDGE, 32'h4);
    wr(A_DATA, 32'hffff_ffff);
    check_reg("ro_data", A_DATA, 32'h5);
    wr(A_RAW, 32'hffff_ffff);
    check_reg("ro_raw", A_RAW, 32'h5);

    // Interrupt path
    wr(A_MASK, 32'hffff_0004);
    check("irq_mask_lag", 32'(irq), 32'h0);
    check_reg("mask_read", A_MASK, IRQ_EN ? 32'h4 : 32'h0);
    step(1);
    check("irq_on_mask", 32'(irq), 32'(IRQ_EN));
    wr(A_EDGE, 32'h4);
    check_reg("w1c_edge2", A_EDGE, 32'h0);
    check("irq_clear_lag", 32'(irq), 32'(IRQ_EN));
    step(1);
    check("irq_cleared", 32'(irq), 32'h0);
    sw_i = 16'h0001;
    e = '0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      rd(A_EDGE, e);
      if (e[2]) break;
    end
    check("edge2_fall", e, 32'h4);
    check("irq_same_cycle_as_edge", 32'(irq), 32'h0);
    step(1);
    check("irq_after_edge", 32'(irq), 32'(IRQ_EN));
    wr(A_MASK, 32'h0);
    step(1);
    check("irq_masked", 32'(irq), 32'h0);
    check_reg("edge_kept_masked", A_EDGE, 32'h4);
    wr(A_EDGE, 32'hffff_ffff);
    check_reg("edge_all_clear", A_EDGE, 32'h0);
    check_reg("data_bit0_only", A_DATA, 32'h1);

    // Bounce: settle bit0 low first, then toggle every 5 cycles
    sw_i = 16'h0000;
    step(HOLD);
    check_reg("bounce_pre_data", A_DATA, 32'h0);
    wr(A_EDGE, 32'hffff_ffff);
    check_reg("bounce_pre_edge", A_EDGE, 32'h0);
    for (int c = 0; c < 50; c++) begin
      sw_i[0] = (c < 40) && (((c / 5) % 2) == 0);
      step(1);
      check_reg("bounce_data", A_DATA, 32'h0);
      check_reg("bounce_edge", A_EDGE, 32'h0);
    end

    // Collision: keep clearing bit1 every cycle until it is accepted
    sw_i  = 16'h0002;
    cs    = 1'b1;
    mem_w = 1'b1;
    addr  = A_EDGE;
    wdata = 32'h2;
    hit   = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      rd(A_DATA, d);
      addr = A_EDGE;
      if (d[1]) begin
        hit = 1;
        break;
      end
    end
    cs    = 1'b0;
    mem_w = 1'b0;
    check("collision_accept_seen", 32'(hit), 32'h1);
    check_reg("collision_edge", A_EDGE, 32'h2);

    // Asynchronous reset in the middle of a debounce
    wr(A_MASK, 32'h2);
    step(1);
    check("irq_pre_reset", 32'(irq), 32'(IRQ_EN));
    sw_i = 16'h0000;
    step(5);
    #3;
    rst = 1'b1;
    #1;
    check("arst_irq", 32'(irq), 32'h0);
    check_reg("arst_data", A_DATA, 32'h0);
    check_reg("arst_edge", A_EDGE, 32'h0);
    check_reg("arst_mask", A_MASK, 32'h0);
    check_reg("arst_raw",  A_RAW,  32'h0);
    step(2);
    @(negedge clk);
    rst = 1'b0;
    step(HOLD);
    check_reg("post_rst_data", A_DATA, 32'h0);
    check_reg("post_rst_edge", A_EDGE, 32'h0);

    // Random phase: level model driven by hold times
    model_data = '0;
    model_edge = '0;
    model_mask = '0;
    cur        = '0;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        g    = WIDTH'($urandom_range(1, 16'hffff));
        sw_i = cur ^ g;
        step($urandom_range(1, 8));
        sw_i = cur;
        step(8);
        exp_q.push_back(32'(model_data));
        exp_q.push_back(32'(model_edge));
        rd(A_DATA, d);
        check("glitch_data", d, exp_q.pop_front());
        rd(A_EDGE, d);
        check("glitch_edge", d, exp_q.pop_front());
      end
      nxt  = WIDTH'($urandom);
      sw_i = nxt;
      step(HOLD);
      model_edge = model_edge | (nxt ^ model_data);
      model_data = nxt;
      cur        = nxt;
      exp_q.push_back(32'(model_data));
      exp_q.push_back(32'(model_data));
      exp_q.push_back(32'(model_edge));
      rd(A_DATA, d);
      check("rand_data", d, exp_q.pop_front());
      rd(A_RAW, d);
      check("rand_raw", d, exp_q.pop_front());
      rd(A_EDGE, d);
      check("rand_edge", d, exp_q.pop_front());
      check("rand_irq_hold", 32'(irq), 32'(IRQ_EN && (|(model_edge & model_mask))));

      w = $urandom;
      wr(A_EDGE, w);
      model_edge = model_edge & ~w[WIDTH-1:0];
      check_reg("rand_w1c", A_EDGE, 32'(model_edge));

      m = $urandom;
      wr(A_MASK, m);
      model_mask = IRQ_EN ? m[WIDTH-1:0] : '0;
      step(1);
      check_reg("rand_mask", A_MASK, 32'(model_mask));
      check("rand_irq", 32'(irq), 32'(IRQ_EN && (|(model_edge & model_mask))));

      wr(A_RAW, $urandom);
      check_reg("rand_ro_raw", A_RAW, 32'(model_data));
    end

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
